instruction_decode_phase: RTL and testbench
===========================================

Name: instruction_decode_phase

Overview:
- ID stage of the 5-stage MIPS pipeline; sits between the IF/ID and ID/EX pipeline registers.
- Decodes the 32-bit instruction into control signals.
- Contains the 32x32 register file, written from the WB stage.
- Produces the sign-extended immediate, the jump target and the instruction fields needed by EX.

Parameters:
- None. Fixed 32-bit datapath, 32 registers.

Ports:
- Clk  in  1  system clock; register file writes on the rising edge
- Reset  in  1  asynchronous reset, active-low
- instr_in  in  32  instruction from IF/ID
- pc_in  in  32  PC+4 of the instruction, from IF/ID
- WriteData  in  32  WB write data
- WriteRegister  in  5  WB destination register
- RegWrite_in  in  1  WB write enable
- RegDst  out  3  destination select: 000 rd, 001 rt, 010 $31
- Jump  out  1  j/jal
- Branch  out  1  beq/bne
- MemRead  out  1  load
- MemtoReg  out  2  writeback source: 00 ALU, 01 memory, 10 pc_in (link)
- ALUOp  out  4  ALU operation class (see Behaviour)
- MemWrite  out  1  store
- ALUSrc  out  1  1 = immediate operand B
- JumpRegister  out  1  jr
- RegWrite_out  out  1  instruction writes a register
- LoadType  out  2  00 word, 01 half, 10 byte
- StoreType  out  2  00 word, 01 half, 10 byte
- JumpTarget  out  32  {pc_in[31:28], instr_in[25:0], 2'b00}
- reg_data1_in  out  32  register file read of rs (instr_in[25:21])
- reg_data2_in  out  32  register file read of rt (instr_in[20:16])
- pc_out  out  32  pc_in passthrough
- sign_ext_offset_in  out  32  instr_in[15:0] sign-extended
- rd_in  out  5  instr_in[15:11]
- rt_in  out  5  instr_in[20:16]
- Shamt_in  out  5  instr_in[10:6]
- ALUop_in  out  6  funct field instr_in[5:0]

Behaviour:
- Timing
  - Decode, field extraction and register reads are combinational; zero latency from instr_in.
  - The only state is the register file.
- Register file
  - On posedge Clk with RegWrite_in=1 and WriteRegister!=0, reg[WriteRegister] <= WriteData.
  - Reads are asynchronous. $0 always reads 0; writes to $0 are ignored.
  - Write-through: if RegWrite_in=1, WriteRegister!=0 and WriteRegister equals the read address, the port returns WriteData in the same cycle.
- Reset
  - Reset low asynchronously clears all 32 registers to 0.
  - While Reset is low, all control outputs are forced to 0. This covers RegDst, Jump, Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, JumpRegister, RegWrite_out, LoadType and StoreType.
  - Field and pass-through outputs stay combinational during reset.
- ALUOp encoding
  - 0000 add
  - 0001 sub
  - 0010 R-type (use funct)
  - 0011 and
  - 0100 or
  - 0101 xor
  - 0110 slt
  - 0111 lui
  - 1000 mul
- Decode by opcode. Signals not listed are 0; LoadType/StoreType are 00 unless listed.
  - 000000 R-type: RegDst=000, RegWrite_out=1, ALUOp=0010.
  - 000000 with funct 001000 (jr): JumpRegister=1, RegWrite_out=0, all else 0.
  - 011100 with funct 000010 (mul): RegDst=000, RegWrite_out=1, ALUOp=1000.
  - 000010 j: Jump=1.
  - 000011 jal: Jump=1, RegDst=010, MemtoReg=10, RegWrite_out=1.
  - 000100 beq / 000101 bne: Branch=1, ALUOp=0001.
  - 001000 addi / 001001 addiu: ALUSrc=1, RegDst=001, RegWrite_out=1, ALUOp=0000.
  - 001010 slti: as addi but ALUOp=0110.
  - 001100 andi / 001101 ori / 001110 xori: as addi, ALUOp 0011 / 0100 / 0101 respectively.
  - 001111 lui: as addi, ALUOp=0111.
  - 100011 lw / 100001 lh / 100000 lb: MemRead=1, MemtoReg=01, ALUSrc=1, RegDst=001, RegWrite_out=1, ALUOp=0000, LoadType 00 / 01 / 10.
  - 101011 sw / 101001 sh / 101000 sb: MemWrite=1, ALUSrc=1, RegDst=001, RegWrite_out=0, ALUOp=0000, StoreType 00 / 01 / 10.
  - Any other opcode: all control outputs 0 (treated as a bubble).
- Immediates and targets
  - sign_ext_offset_in is always sign-extended; zero-extension for logical immediates is done in EX.
  - JumpTarget is computed for every instruction; it is used only when Jump=1.
- Simultaneous WB write and decode read of the same register resolves via write-through.

Test Plan:
1. Reset low, then read rs=rt=5 -> reg_data1_in = reg_data2_in = 0; all control outputs 0.
2. Reset high, instr 0x8C010000 (lw $1,0($0)), pc_in=4 -> RegDst=001, MemRead=1, MemtoReg=01, ALUSrc=1, RegWrite_out=1, MemWrite=0, Jump=0, Branch=0, LoadType=00, rt_in=1.
3. instr 0xAC010000 (sw $1,0($0)), pc_in=8 -> MemWrite=1, MemRead=0, ALUSrc=1, RegWrite_out=0, StoreType=00.
4. Write 0xDEADBEEF to $3 (RegWrite_in=1) on one edge; next cycle instr 0x00631020 (add $2,$3,$3) -> both reads 0xDEADBEEF, RegDst=000, ALUOp=0010, ALUop_in=100000, rd_in=2. Same-cycle read during the write -> write-through value. Write to $0 -> $0 still reads 0.
5. instr 0x0C000010 (jal), pc_in=0x40000004 -> Jump=1, RegDst=010, MemtoReg=10, JumpTarget=0x40000040.
6. instr 0x2002FFFF (addi $2,$0,-1) -> sign_ext_offset_in=0xFFFFFFFF, ALUSrc=1. instr 0x03E00008 (jr $31) -> JumpRegister=1, RegWrite_out=0. Opcode 111111 -> all control 0.

Source files
------------

// File: rtl/instruction_decode_phase.sv
// MIPS ID stage: opcode/funct decode into control, 32x32 register file with WB
// write-through, sign-extended immediate, jump target and EX field extraction.
module instruction_decode_phase (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] WriteData,
  input  logic [4:0]  WriteRegister,
  input  logic        RegWrite_in,
  output logic [2:0]  RegDst,
  output logic        Jump,
  output logic        Branch,
  output logic        MemRead,
  output logic [1:0]  MemtoReg,
  output logic [3:0]  ALUOp,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        JumpRegister,
  output logic        RegWrite_out,
  output logic [1:0]  LoadType,
  output logic [1:0]  StoreType,
  output logic [31:0] JumpTarget,
  output logic [31:0] reg_data1_in,
  output logic [31:0] reg_data2_in,
  output logic [31:0] pc_out,
  output logic [31:0] sign_ext_offset_in,
  output logic [4:0]  rd_in,
  output logic [4:0]  rt_in,
  output logic [4:0]  Shamt_in,
  output logic [5:0]  ALUop_in
);

  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] OP_JAL      = 6'b000011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BNE      = 6'b000101;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_ADDIU    = 6'b001001;
  localparam logic [5:0] OP_SLTI     = 6'b001010;
  localparam logic [5:0] OP_ANDI     = 6'b001100;
  localparam logic [5:0] OP_ORI      = 6'b001101;
  localparam logic [5:0] OP_XORI     = 6'b001110;
  localparam logic [5:0] OP_LUI      = 6'b001111;
  localparam logic [5:0] OP_LB       = 6'b100000;
  localparam logic [5:0] OP_LH       = 6'b100001;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_SB       = 6'b101000;
  localparam logic [5:0] OP_SH       = 6'b101001;
  localparam logic [5:0] OP_SW       = 6'b101011;
  localparam logic [5:0] FUNCT_JR    = 6'b001000;
  localparam logic [5:0] FUNCT_MUL   = 6'b000010;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_RTYPE = 4'b0010,
    ALU_AND   = 4'b0011,
    ALU_OR    = 4'b0100,
    ALU_XOR   = 4'b0101,
    ALU_SLT   = 4'b0110,
    ALU_LUI   = 4'b0111,
    ALU_MUL   = 4'b1000
  } alu_op_e;

  typedef struct packed {
    logic [2:0] reg_dst;
    logic       jump;
    logic       branch;
    logic       mem_read;
    logic [1:0] mem_to_reg;
    alu_op_e    alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       jump_register;
    logic       reg_write;
    logic [1:0] load_type;
    logic [1:0] store_type;
  } ctrl_t;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] regs_q [32];
  ctrl_t       ctrl;

  assign opcode  = instr_in[31:26];
  assign funct   = instr_in[5:0];
  assign rs_addr = instr_in[25:21];
  assign rt_addr = instr_in[20:16];

  // NOTE: the register file is reset because software relies on clean
  // registers after reset; this forces it into flops rather than a RAM macro.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (RegWrite_in && (WriteRegister != 5'd0)) begin
      // NOTE: non-blocking so every reader sees the pre-edge value this cycle.
      regs_q[WriteRegister] <= WriteData;
    end
  end

  // $0 is hardwired; a WB write to the addressed register is forwarded.
  always_comb begin
    reg_data1_in = regs_q[rs_addr];
    reg_data2_in = regs_q[rt_addr];
    if (Reset && RegWrite_in && (WriteRegister == rs_addr)) reg_data1_in = WriteData;
    if (Reset && RegWrite_in && (WriteRegister == rt_addr)) reg_data2_in = WriteData;
    if (rs_addr == 5'd0) reg_data1_in = '0;
    if (rt_addr == 5'd0) reg_data2_in = '0;
  end

  always_comb begin
    // NOTE: default every field first so no path through the case infers a latch.
    ctrl = '0;
    unique case (opcode)
      OP_RTYPE: begin
        if (funct == FUNCT_JR) begin
          ctrl.jump_register = 1'b1;
        end else begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALU_RTYPE;
        end
      end
      OP_SPECIAL2: begin
        if (funct == FUNCT_MUL) begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALU_MUL;
        end
      end
      OP_J: ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump       = 1'b1;
        ctrl.reg_dst    = 3'b010;
        ctrl.mem_to_reg = 2'b10;
        ctrl.reg_write  = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_dst   = 3'b001;
        ctrl.reg_write = 1'b1;
        case (opcode)
          OP_SLTI: ctrl.alu_op = ALU_SLT;
          OP_ANDI: ctrl.alu_op = ALU_AND;
          OP_ORI:  ctrl.alu_op = ALU_OR;
          OP_XORI: ctrl.alu_op = ALU_XOR;
          OP_LUI:  ctrl.alu_op = ALU_LUI;
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      OP_LW, OP_LH, OP_LB: begin
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 2'b01;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_dst    = 3'b001;
        ctrl.reg_write  = 1'b1;
        ctrl.load_type  = (opcode == OP_LH) ? 2'b01 : (opcode == OP_LB) ? 2'b10 : 2'b00;
      end
      OP_SW, OP_SH, OP_SB: begin
        ctrl.mem_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_dst    = 3'b001;
        ctrl.store_type = (opcode == OP_SH) ? 2'b01 : (opcode == OP_SB) ? 2'b10 : 2'b00;
      end
      default: ctrl = '0;
    endcase
    if (!Reset) ctrl = '0;
  end

  assign RegDst       = ctrl.reg_dst;
  assign Jump         = ctrl.jump;
  assign Branch       = ctrl.branch;
  assign MemRead      = ctrl.mem_read;
  assign MemtoReg     = ctrl.mem_to_reg;
  assign ALUOp        = ctrl.alu_op;
  assign MemWrite     = ctrl.mem_write;
  assign ALUSrc       = ctrl.alu_src;
  assign JumpRegister = ctrl.jump_register;
  assign RegWrite_out = ctrl.reg_write;
  assign LoadType     = ctrl.load_type;
  assign StoreType    = ctrl.store_type;

  assign JumpTarget         = {pc_in[31:28], instr_in[25:0], 2'b00};
  assign pc_out             = pc_in;
  assign sign_ext_offset_in = {{16{instr_in[15]}}, instr_in[15:0]};
  assign rd_in              = instr_in[15:11];
  assign rt_in              = rt_addr;
  assign Shamt_in           = instr_in[10:6];
  assign ALUop_in           = funct;

endmodule

// File: tb/tb_instruction_decode_phase.sv
// Directed bench for instruction_decode_phase: decode table, register file,
// write-through, $0, reset behaviour and immediate/jump field extraction.
module tb_instruction_decode_phase;

  logic        Clk;
  logic        Reset;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic [31:0] WriteData;
  logic [4:0]  WriteRegister;
  logic        RegWrite_in;
  logic [2:0]  RegDst;
  logic        Jump;
  logic        Branch;
  logic        MemRead;
  logic [1:0]  MemtoReg;
  logic [3:0]  ALUOp;
  logic        MemWrite;
  logic        ALUSrc;
  logic        JumpRegister;
  logic        RegWrite_out;
  logic [1:0]  LoadType;
  logic [1:0]  StoreType;
  logic [31:0] JumpTarget;
  logic [31:0] reg_data1_in;
  logic [31:0] reg_data2_in;
  logic [31:0] pc_out;
  logic [31:0] sign_ext_offset_in;
  logic [4:0]  rd_in;
  logic [4:0]  rt_in;
  logic [4:0]  Shamt_in;
  logic [5:0]  ALUop_in;

  int vectors;
  int miscompares;

  instruction_decode_phase dut (
    .Clk(Clk), .Reset(Reset), .instr_in(instr_in), .pc_in(pc_in),
    .WriteData(WriteData), .WriteRegister(WriteRegister), .RegWrite_in(RegWrite_in),
    .RegDst(RegDst), .Jump(Jump), .Branch(Branch), .MemRead(MemRead),
    .MemtoReg(MemtoReg), .ALUOp(ALUOp), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
    .JumpRegister(JumpRegister), .RegWrite_out(RegWrite_out), .LoadType(LoadType),
    .StoreType(StoreType), .JumpTarget(JumpTarget), .reg_data1_in(reg_data1_in),
    .reg_data2_in(reg_data2_in), .pc_out(pc_out), .sign_ext_offset_in(sign_ext_offset_in),
    .rd_in(rd_in), .rt_in(rt_in), .Shamt_in(Shamt_in), .ALUop_in(ALUop_in)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Control outputs packed in port order:
  // RegDst, Jump, Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc,
  // JumpRegister, RegWrite_out, LoadType, StoreType
  logic [19:0] ctrl_obs;
  assign ctrl_obs = {RegDst, Jump, Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc,
                     JumpRegister, RegWrite_out, LoadType, StoreType};

  function automatic logic [19:0] cv(input logic [2:0] rdst, input logic j, input logic b,
                                     input logic mr, input logic [1:0] m2r,
                                     input logic [3:0] aop, input logic mw, input logic as,
                                     input logic jr, input logic rw,
                                     input logic [1:0] lt, input logic [1:0] st);
    return {rdst, j, b, mr, m2r, aop, mw, as, jr, rw, lt, st};
  endfunction

  task automatic test_reset();
    RegWrite_in = 1'b0;
    instr_in    = 32'h8CA5_0000;
    pc_in       = 32'h0000_0000;
    Reset       = 1'b1;
    #2 Reset    = 1'b0;
    @(posedge Clk); #1;
    vectors++;
    if (reg_data1_in !== 32'h0 || reg_data2_in !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_regs: got rs=%h rt=%h expected 0/0", reg_data1_in, reg_data2_in);
    end
    vectors++;
    if (ctrl_obs !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %h expected 00000", ctrl_obs);
    end
    vectors++;
    if (rt_in !== 5'd5) begin
      miscompares++;
      $display("FAIL reset_field_rt: got %0d expected 5", rt_in);
    end
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic test_load_store();
    instr_in = 32'h8C01_0000; pc_in = 32'd4; #1;
    vectors++;
    if (ctrl_obs !== cv(3'b001,0,0,1,2'b01,4'b0000,0,1,0,1,2'b00,2'b00)) begin
      miscompares++;
      $display("FAIL lw_ctrl: got %h expected %h", ctrl_obs,
               cv(3'b001,0,0,1,2'b01,4'b0000,0,1,0,1,2'b00,2'b00));
    end
    vectors++;
    if (rt_in !== 5'd1 || pc_out !== 32'd4) begin
      miscompares++;
      $display("FAIL lw_fields: got rt=%0d pc=%h expected rt=1 pc=00000004", rt_in, pc_out);
    end
    instr_in = 32'hAC01_0000; pc_in = 32'd8; #1;
    vectors++;
    if (ctrl_obs !== cv(3'b001,0,0,0,2'b00,4'b0000,1,1,0,0,2'b00,2'b00)) begin
      miscompares++;
      $display("FAIL sw_ctrl: got %h expected %h", ctrl_obs,
               cv(3'b001,0,0,0,2'b00,4'b0000,1,1,0,0,2'b00,2'b00));
    end
  endtask

  task automatic test_decode_table();
    logic [31:0] instrs [18];
    logic [19:0] exps   [18];
    instrs[0]  = 32'h8401_0000; exps[0]  = cv(3'b001,0,0,1,2'b01,4'b0000,0,1,0,1,2'b01,2'b00); // lh
    instrs[1]  = 32'h8001_0000; exps[1]  = cv(3'b001,0,0,1,2'b01,4'b0000,0,1,0,1,2'b10,2'b00); // lb
    instrs[2]  = 32'hA401_0000; exps[2]  = cv(3'b001,0,0,0,2'b00,4'b0000,1,1,0,0,2'b00,2'b01); // sh
    instrs[3]  = 32'hA001_0000; exps[3]  = cv(3'b001,0,0,0,2'b00,4'b0000,1,1,0,0,2'b00,2'b10); // sb
    instrs[4]  = 32'h7022_1002; exps[4]  = cv(3'b000,0,0,0,2'b00,4'b1000,0,0,0,1,2'b00,2'b00); // mul
    instrs[5]  = 32'h7000_0001; exps[5]  = 20'h0;                                               // special2 non-mul
    instrs[6]  = 32'h0800_0010; exps[6]  = cv(3'b000,1,0,0,2'b00,4'b0000,0,0,0,0,2'b00,2'b00); // j
    instrs[7]  = 32'h1022_0003; exps[7]  = cv(3'b000,0,1,0,2'b00,4'b0001,0,0,0,0,2'b00,2'b00); // beq
    instrs[8]  = 32'h1422_0003; exps[8]  = cv(3'b000,0,1,0,2'b00,4'b0001,0,0,0,0,2'b00,2'b00); // bne
    instrs[9]  = 32'h2402_FFFF; exps[9]  = cv(3'b001,0,0,0,2'b00,4'b0000,0,1,0,1,2'b00,2'b00); // addiu
    instrs[10] = 32'h2822_0005; exps[10] = cv(3'b001,0,0,0,2'b00,4'b0110,0,1,0,1,2'b00,2'b00); // slti
    instrs[11] = 32'h3022_0005; exps[11] = cv(3'b001,0,0,0,2'b00,4'b0011,0,1,0,1,2'b00,2'b00); // andi
    instrs[12] = 32'h3422_0005; exps[12] = cv(3'b001,0,0,0,2'b00,4'b0100,0,1,0,1,2'b00,2'b00); // ori
    instrs[13] = 32'h3822_0005; exps[13] = cv(3'b001,0,0,0,2'b00,4'b0101,0,1,0,1,2'b00,2'b00); // xori
    instrs[14] = 32'h3C02_0005; exps[14] = cv(3'b001,0,0,0,2'b00,4'b0111,0,1,0,1,2'b00,2'b00); // lui
    instrs[15] = 32'h03E0_0008; exps[15] = cv(3'b000,0,0,0,2'b00,4'b0000,0,0,1,0,2'b00,2'b00); // jr
    instrs[16] = 32'hFC00_0000; exps[16] = 20'h0;                                               // bad opcode
    instrs[17] = 32'h0002_1140; exps[17] = cv(3'b000,0,0,0,2'b00,4'b0010,0,0,0,1,2'b00,2'b00); // sll
    for (int i = 0; i < 18; i++) begin
      instr_in = instrs[i]; #1;
      vectors++;
      if (ctrl_obs !== exps[i]) begin
        miscompares++;
        $display("FAIL decode_%0d (instr %h): got %h expected %h", i, instrs[i], ctrl_obs, exps[i]);
      end
    end
    instr_in = 32'h0002_1140; #1;
    vectors++;
    if (Shamt_in !== 5'd5 || rd_in !== 5'd2 || ALUop_in !== 6'b000000) begin
      miscompares++;
      $display("FAIL sll_fields: got shamt=%0d rd=%0d funct=%b expected 5/2/000000",
               Shamt_in, rd_in, ALUop_in);
    end
  endtask

  task automatic test_regfile();
    @(negedge Clk);
    instr_in = 32'h0063_1020; WriteRegister = 5'd3; WriteData = 32'hDEAD_BEEF; RegWrite_in = 1'b1;
    #1;
    vectors++;
    if (reg_data1_in !== 32'hDEAD_BEEF || reg_data2_in !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL write_through: got %h/%h expected deadbeef/deadbeef", reg_data1_in, reg_data2_in);
    end
    @(posedge Clk); #1;
    RegWrite_in = 1'b0; WriteData = 32'h0; #1;
    vectors++;
    if (reg_data1_in !== 32'hDEAD_BEEF || reg_data2_in !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL stored_read: got %h/%h expected deadbeef/deadbeef", reg_data1_in, reg_data2_in);
    end
    vectors++;
    if (ctrl_obs !== cv(3'b000,0,0,0,2'b00,4'b0010,0,0,0,1,2'b00,2'b00)
        || ALUop_in !== 6'b100000 || rd_in !== 5'd2) begin
      miscompares++;
      $display("FAIL add_decode: got ctrl=%h funct=%b rd=%0d expected %h/100000/2", ctrl_obs,
               ALUop_in, rd_in, cv(3'b000,0,0,0,2'b00,4'b0010,0,0,0,1,2'b00,2'b00));
    end
    @(negedge Clk);
    WriteRegister = 5'd7; WriteData = 32'h1234_5678; RegWrite_in = 1'b1;
    @(posedge Clk); #1;
    RegWrite_in = 1'b0; instr_in = 32'h0067_1020; #1;
    vectors++;
    if (reg_data1_in !== 32'hDEAD_BEEF || reg_data2_in !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL two_regs: got %h/%h expected deadbeef/12345678", reg_data1_in, reg_data2_in);
    end
    @(negedge Clk);
    instr_in = 32'h0000_0020; WriteRegister = 5'd0; WriteData = 32'hFFFF_FFFF; RegWrite_in = 1'b1;
    #1;
    vectors++;
    if (reg_data1_in !== 32'h0 || reg_data2_in !== 32'h0) begin
      miscompares++;
      $display("FAIL r0_bypass: got %h/%h expected 0/0", reg_data1_in, reg_data2_in);
    end
    @(posedge Clk); #1;
    RegWrite_in = 1'b0; #1;
    vectors++;
    if (reg_data1_in !== 32'h0 || reg_data2_in !== 32'h0) begin
      miscompares++;
      $display("FAIL r0_write: got %h/%h expected 0/0", reg_data1_in, reg_data2_in);
    end
    // Asynchronous reset mid-run clears registers and masks control.
    instr_in = 32'h0067_1020; #2;
    Reset = 1'b0; #1;
    vectors++;
    if (reg_data1_in !== 32'h0 || reg_data2_in !== 32'h0 || ctrl_obs !== 20'h0 || rt_in !== 5'd7) begin
      miscompares++;
      $display("FAIL async_reset: got %h/%h ctrl=%h rt=%0d expected 0/0 ctrl=00000 rt=7",
               reg_data1_in, reg_data2_in, ctrl_obs, rt_in);
    end
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic test_jump_imm();
    instr_in = 32'h0C00_0010; pc_in = 32'h4000_0004; #1;
    vectors++;
    if (ctrl_obs !== cv(3'b010,1,0,0,2'b10,4'b0000,0,0,0,1,2'b00,2'b00)) begin
      miscompares++;
      $display("FAIL jal_ctrl: got %h expected %h", ctrl_obs,
               cv(3'b010,1,0,0,2'b10,4'b0000,0,0,0,1,2'b00,2'b00));
    end
    vectors++;
    if (JumpTarget !== 32'h4000_0040) begin
      miscompares++;
      $display("FAIL jal_target: got %h expected 40000040", JumpTarget);
    end
    instr_in = 32'h2002_FFFF; #1;
    vectors++;
    if (sign_ext_offset_in !== 32'hFFFF_FFFF ||
        ctrl_obs !== cv(3'b001,0,0,0,2'b00,4'b0000,0,1,0,1,2'b00,2'b00)) begin
      miscompares++;
      $display("FAIL addi_neg: got imm=%h ctrl=%h expected ffffffff/%h", sign_ext_offset_in,
               ctrl_obs, cv(3'b001,0,0,0,2'b00,4'b0000,0,1,0,1,2'b00,2'b00));
    end
    instr_in = 32'h2002_7FFF; #1;
    vectors++;
    if (sign_ext_offset_in !== 32'h0000_7FFF) begin
      miscompares++;
      $display("FAIL addi_pos: got imm=%h expected 00007fff", sign_ext_offset_in);
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    Reset         = 1'b1;
    instr_in      = '0;
    pc_in         = '0;
    WriteData     = '0;
    WriteRegister = '0;
    RegWrite_in   = 1'b0;
    test_reset();
    test_load_store();
    test_decode_table();
    test_regfile();
    test_jump_imm();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
